// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM encodings, idle patterns
// and the matrix-position to hex-code key map.
package keypad_scan_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  localparam logic [3:0] ROW_FIRST = 4'b1110;
  localparam logic [3:0] COL_NONE  = 4'b1111;

  // True when exactly one line of an active-low group is asserted.
  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotate_row(input logic [3:0] row);
    return {row[2:0], row[3]};
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the decoded-key outputs; master is the
// keypad/host side, slave is the scanner.
interface keypad_scan_if;
  logic [3:0]  kbd_col;
  logic [3:0]  kbd_row;
  logic        data_clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [31:0] key_data;

  modport master (
    output kbd_col, data_clr,
    input  kbd_row, key_valid, key_code, key_pressed, key_data
  );

  modport slave (
    input  kbd_col, data_clr,
    output kbd_row, key_valid, key_code, key_pressed, key_data
  );
endinterface

// File: rtl/keypad_scan_sync2.sv
// Generic two-flop synchronizer with a configurable reset value so
// pulled-up inputs come out of reset as "inactive".
module keypad_scan_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] stable;

  // NOTE: non-blocking assignments make meta->stable a true two-stage shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= RESET_VAL;
      stable <= RESET_VAL;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign q = stable;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row strobing, tick-based debounce of press and release,
// one key_valid pulse per accepted press and a 32-bit hex digit shifter.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic clk,
  input  logic reset,
  keypad_scan_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       col_sync;
  logic [DIV_W-1:0] divider;
  logic             tick;

  logic [1:0]       state;
  logic [3:0]       row;
  logic [3:0]       col_pat;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] cnt;

  logic             key_valid_q;
  logic [3:0]       key_code_q;
  logic             key_pressed_q;
  logic [31:0]      key_data_q;

  keypad_scan_sync2 #(
    .WIDTH     (4),
    .RESET_VAL (COL_NONE)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.kbd_col),
    .q     (col_sync)
  );

  assign tick = (divider == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     divider <= '0;
    else if (tick) divider <= '0;
    else           divider <= divider + 1'b1;
  end

  // Columns are only looked at on ticks; between ticks the FSM idles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_SCAN;
      row           <= ROW_FIRST;
      col_pat       <= COL_NONE;
      row_idx       <= 2'd0;
      col_idx       <= 2'd0;
      cnt           <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
    end else begin
      // NOTE: default-low here with a single set below keeps key_valid a one-clk pulse.
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (one_low(col_sync)) begin
              row_idx <= low_index(row);
              col_idx <= low_index(col_sync);
              col_pat <= col_sync;
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              row <= rotate_row(row);
            end
          end
          ST_DEBOUNCE: begin
            if (col_sync == col_pat) begin
              if (cnt == CNT_LAST) begin
                cnt           <= '0;
                state         <= ST_HOLD;
                key_code_q    <= key_map(row_idx, col_idx);
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= ST_SCAN;
              row   <= rotate_row(row);
            end
          end
          ST_HOLD: begin
            if (col_sync == COL_NONE) begin
              if (cnt == CNT_LAST) begin
                cnt           <= '0;
                state         <= ST_SCAN;
                key_pressed_q <= 1'b0;
                row           <= rotate_row(row);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: begin
            state <= ST_SCAN;
            row   <= ROW_FIRST;
          end
        endcase
      end
    end
  end

  // Clear has priority over a coincident new digit.
  always_ff @(posedge clk) begin
    if (reset)            key_data_q <= 32'h0;
    else if (bus.data_clr) key_data_q <= 32'h0;
    else if (key_valid_q) key_data_q <= {key_data_q[27:0], key_code_q};
  end

  assign bus.kbd_row     = row;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_pressed = key_pressed_q;
  assign bus.key_data    = key_data_q;

endmodule
